// File: rtl/dtree_seq_eval.sv
// dtree_seq_eval: run-time programmable decision-tree classifier, one node per clock.
// Optional DTREE_DEPTH_OUT_EN adds out_depth (internal-node count of the result).
module dtree_seq_eval #(
    parameter int N_FEAT = 5,
    parameter int FEAT_W = 8,
    parameter int CLASS_W = 5,
    parameter int N_NODES = 16,
    parameter int MAX_DEPTH = 8,
    localparam int IDX_W = $clog2(N_NODES),
    localparam int FSEL_W = $clog2(N_FEAT),
    localparam int NODE_W = 1 + FSEL_W + FEAT_W + 2 * IDX_W,
    localparam int DEP_W = $clog2(MAX_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_we,
    input  logic [IDX_W-1:0]         cfg_addr,
    input  logic [NODE_W-1:0]        cfg_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_FEAT*FEAT_W-1:0] in_feat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CLASS_W-1:0]       out_class,
`ifdef DTREE_DEPTH_OUT_EN
    output logic [DEP_W-1:0]         out_depth,
`endif
    output logic                     out_err
);
    typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;
    localparam logic [NODE_W-1:0] RST_NODE = {1'b1, {(NODE_W-1){1'b0}}};

    state_t                          state;
    logic [NODE_W-1:0]               tbl [N_NODES];
    logic [N_FEAT-1:0][FEAT_W-1:0]   feat_q;
    logic [IDX_W-1:0]                node;
    logic [DEP_W-1:0]                step;

    logic [NODE_W-1:0] node_w;
    logic              leaf, bad_feat, bad_child, abort;
    logic [FSEL_W-1:0] fsel, fsel_ok;
    logic [FEAT_W-1:0] thr, fval;
    logic [IDX_W-1:0]  left, right, child;

    // table mux -> feature mux -> comparator -> next-node mux
    always_comb begin
        node_w    = tbl[node];
        leaf      = node_w[NODE_W-1];
        fsel      = node_w[NODE_W-2 -: FSEL_W];
        thr       = node_w[2*IDX_W +: FEAT_W];
        left      = node_w[IDX_W +: IDX_W];
        right     = node_w[0 +: IDX_W];
        bad_feat  = {1'b0, fsel} >= (FSEL_W+1)'(N_FEAT);
        fsel_ok   = bad_feat ? '0 : fsel;
        fval      = feat_q[fsel_ok];
        child     = (fval <= thr) ? left : right;
        bad_child = {1'b0, child} >= (IDX_W+1)'(N_NODES);
        abort     = bad_feat || bad_child || step == DEP_W'(MAX_DEPTH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_class <= '0;
            out_err   <= 1'b0;
            node      <= '0;
            step      <= '0;
            feat_q    <= '0;
`ifdef DTREE_DEPTH_OUT_EN
            out_depth <= '0;
`endif
            for (int i = 0; i < N_NODES; i++) tbl[i] <= RST_NODE;
        end else begin
            case (state)
                IDLE: begin
                    if (cfg_we && {1'b0, cfg_addr} < (IDX_W+1)'(N_NODES)) tbl[cfg_addr] <= cfg_data;
                    if (in_valid) begin
                        feat_q   <= in_feat;
                        node     <= '0;
                        step     <= '0;
                        in_ready <= 1'b0;
                        state    <= WALK;
                    end
                end
                WALK: begin
                    if (leaf || abort) begin
                        out_class <= leaf ? thr[CLASS_W-1:0] : '0;
                        out_err   <= !leaf;
                        out_valid <= 1'b1;
`ifdef DTREE_DEPTH_OUT_EN
                        out_depth <= step;
`endif
                        state     <= DONE;
                    end else begin
                        node <= child;
                        step <= step + 1'b1;
                    end
                end
                default: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dtree_seq_eval.sv
// tb_dtree_seq_eval: table-driven, hand-written and randomized checks against a tree-walk model.
module tb_dtree_seq_eval;
    logic        clk = 0, rst = 1;
    logic        cfg_we = 0;
    logic [3:0]  cfg_addr = 0;
    logic [19:0] cfg_data = 0;
    logic        in_valid = 0, in_ready, out_valid, out_ready = 0, out_err;
    logic [39:0] in_feat = 0;
    logic [4:0]  out_class;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    dtree_seq_eval dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_feat(in_feat),
        .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class), .out_err(out_err)
    );

    typedef struct {bit leaf; int feat; int thr; int l; int r;} mnode_t;
    mnode_t mt [16];

    typedef struct {logic [39:0] f; int cls; int err; int lat;} vec_t;
    vec_t vt [4];

    task automatic chk(input string n, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", n, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) mt[i] = '{1, 0, 0, 0, 0};
    endfunction

    // walk the tree from the root as the classification rules describe
    function automatic void model(input logic [39:0] f, output int cls, output int err, output int k);
        int n = 0, ch, fv;
        k = 0;
        forever begin
            if (mt[n].leaf) begin
                cls = mt[n].thr % 32; err = 0; return;
            end
            if (mt[n].feat >= 5 || k == 8) begin
                cls = 0; err = 1; return;
            end
            fv = int'(f[mt[n].feat*8 +: 8]);
            ch = (fv <= mt[n].thr) ? mt[n].l : mt[n].r;
            if (ch >= 16) begin
                cls = 0; err = 1; return;
            end
            n = ch;
            k++;
        end
    endfunction

    task automatic prog(input int a, input bit lf, input int ft, input int th, input int l, input int r);
        @(negedge clk);
        cfg_we = 1; cfg_addr = 4'(a);
        cfg_data = {lf, 3'(ft), 8'(th), 4'(l), 4'(r)};
        @(posedge clk); #1;
        cfg_we = 0;
        mt[a] = '{lf, ft, th, l, r};
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run(input logic [39:0] f, input int stall, output int cls, output int err, output int lat);
        @(negedge clk);
        in_feat = f; in_valid = 1;
        @(posedge clk); #1;
        in_valid = 0;
        in_feat = 40'({$urandom(), $urandom()});
        wait_valid(lat);
        cls = int'(out_class); err = int'(out_err);
        repeat (stall) @(posedge clk);
        #1;
        if (stall > 0) chk("stall_class", int'(out_class), cls);
        @(negedge clk);
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        chk("handshake_rdy_vld", int'({in_ready, out_valid}), 2);
    endtask

    initial begin
        int cls, err, lat, ec, ee, ek;
        model_reset();
        #12;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_class", int'(out_class), 0);
        chk("rst_out_err", int'(out_err), 0);
        @(negedge clk); rst = 0;

        run(40'h0, 0, cls, err, lat);
        chk("unprog_class", cls, 0); chk("unprog_err", err, 0); chk("unprog_lat", lat, 1);

        prog(0, 0, 4, 8'h3F, 1, 2);
        prog(1, 1, 0, 167, 0, 0);
        prog(2, 1, 0, 24, 0, 0);
        vt[0] = '{40'h3F_00000000, 7, 0, 2};
        vt[1] = '{40'h40_00000000, 24, 0, 2};
        vt[2] = '{40'h00_FFFFFFFF, 7, 0, 2};
        vt[3] = '{40'hFF_00000000, 24, 0, 2};
        for (int i = 0; i < 4; i++) begin
            run(vt[i].f, i, cls, err, lat);
            chk($sformatf("tbl%0d_class", i), cls, vt[i].cls);
            chk($sformatf("tbl%0d_err", i), err, vt[i].err);
            chk($sformatf("tbl%0d_lat", i), lat, vt[i].lat);
        end

        // chain of 9 internal nodes: depth limit hit on the 9th
        for (int i = 0; i < 9; i++) prog(i, 0, 0, 8'hFF, i + 1, i + 1);
        prog(9, 1, 0, 3, 0, 0);
        run(40'h0, 0, cls, err, lat);
        chk("chain9_class", cls, 0); chk("chain9_err", err, 1); chk("chain9_lat", lat, 9);
        prog(8, 1, 0, 5, 0, 0);
        run(40'h0, 0, cls, err, lat);
        chk("chain8_class", cls, 5); chk("chain8_err", err, 0); chk("chain8_lat", lat, 9);

        prog(0, 0, 6, 0, 1, 1);
        run(40'h0, 0, cls, err, lat);
        chk("feat6_err", err, 1); chk("feat6_lat", lat, 1); chk("feat6_class", cls, 0);
        prog(0, 0, 5, 0, 1, 1);
        run(40'h0, 0, cls, err, lat);
        chk("feat5_err", err, 1);

        // DONE stall with noise on in_valid and cfg_we
        prog(0, 1, 0, 11, 0, 0);
        @(negedge clk); in_valid = 1;
        @(posedge clk); #1; in_valid = 0;
        wait_valid(lat);
        chk("stall_lat", lat, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            in_valid = c[0]; cfg_we = 1; cfg_addr = 0; cfg_data = {1'b1, 3'd0, 8'd22, 8'd0};
            @(posedge clk); #1;
            chk("stall_valid", int'(out_valid), 1);
            chk("stall_cls", int'(out_class), 11);
            chk("stall_in_ready", int'(in_ready), 0);
        end
        in_valid = 0; cfg_we = 0;
        @(negedge clk); out_ready = 1;
        @(posedge clk); #1; out_ready = 0;
        chk("stall_release", int'({in_ready, out_valid}), 2);
        run(40'h0, 0, cls, err, lat);
        chk("table_unchanged", cls, 11);

        // write in the accept cycle is seen by the walk
        @(negedge clk);
        cfg_we = 1; cfg_addr = 0; cfg_data = {1'b1, 3'd0, 8'd9, 8'd0}; in_valid = 1;
        @(posedge clk); #1; cfg_we = 0; in_valid = 0;
        mt[0] = '{1, 0, 9, 0, 0};
        wait_valid(lat);
        chk("wr_accept_class", int'(out_class), 9);
        @(negedge clk); out_ready = 1;
        @(posedge clk); #1; out_ready = 0;

        // reset mid-walk discards the walk and clears the table
        for (int i = 0; i < 9; i++) prog(i, 0, 0, 8'hFF, i + 1, i + 1);
        @(negedge clk); in_valid = 1;
        @(posedge clk); #1; in_valid = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1;
        @(negedge clk); rst = 0;
        model_reset();
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("rst_walk_valid", int'(out_valid), 0);
        end
        run(40'h0, 0, cls, err, lat);
        chk("post_rst_class", cls, 0); chk("post_rst_lat", lat, 1);
        prog(0, 0, 0, 8'h80, 5, 6);
        run(40'h0, 0, cls, err, lat);
        chk("post_rst_n5", cls + 10 * err, 0); chk("post_rst_n5_lat", lat, 2);
        run(40'hFF, 0, cls, err, lat);
        chk("post_rst_n6", cls + 10 * err, 0);

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 16; i++)
                prog(i, $urandom_range(0, 2) == 0,
                     ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, 4),
                     ($urandom_range(0, 3) == 0) ? ($urandom_range(0, 15) * 16 + 15) : $urandom_range(0, 255),
                     $urandom_range(0, 15), $urandom_range(0, 15));
            for (int v = 0; v < 10; v++) begin
                logic [39:0] f;
                f = 40'({$urandom(), $urandom()});
                model(f, ec, ee, ek);
                run(f, $urandom_range(0, 2), cls, err, lat);
                chk("rnd_class", cls, ec);
                chk("rnd_err", err, ee);
                chk("rnd_lat", lat, ek + 1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
